// File: rtl/vx_ifetch_buffer.sv
// vx_ifetch_buffer: elastic FIFO between icache response and decode.
// Define VX_IFETCH_BUF_BYPASS_EN to pass an input straight through to decode when the buffer is empty.
module vx_ifetch_buffer #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int DEPTH       = 4,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNT_BITS   = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    input  logic [NW_BITS-1:0]     in_wid_i,
    input  logic [NUM_THREADS-1:0] in_tmask_i,
    input  logic [31:0]            in_pc_i,
    input  logic [31:0]            in_instr_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic [NW_BITS-1:0]     out_wid_o,
    output logic [NUM_THREADS-1:0] out_tmask_o,
    output logic [31:0]            out_pc_o,
    output logic [31:0]            out_instr_o,
    input  logic                   out_ready_i,
    output logic [CNT_BITS-1:0]    count_o,
    output logic                   busy_o
);
    localparam int AW = $clog2(DEPTH);

    logic [NW_BITS-1:0]     wid_q   [DEPTH];
    logic [NUM_THREADS-1:0] tmask_q [DEPTH];
    logic [31:0]            pc_q    [DEPTH];
    logic [31:0]            instr_q [DEPTH];
    logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [CNT_BITS-1:0]    count_q, count_d;
    logic                   byp, stored_valid, push_st, pop_st;

`ifdef VX_IFETCH_BUF_BYPASS_EN
    assign byp = (count_q == '0) && in_valid_i && out_ready_i && !flush_i && !reset_i;
`else
    assign byp = 1'b0;
`endif

    assign in_ready_o   = !reset_i && !flush_i && (count_q != CNT_BITS'(DEPTH));
    assign stored_valid = (count_q != '0) && !flush_i && !reset_i;
    assign out_valid_o  = byp || stored_valid;
    // A bypassed entry is consumed the same cycle, so it never touches the array.
    assign push_st = in_valid_i && in_ready_o && !byp;
    assign pop_st  = stored_valid && out_ready_i;

    always_comb begin
        out_wid_o   = byp ? in_wid_i   : stored_valid ? wid_q[rd_q]   : '0;
        out_tmask_o = byp ? in_tmask_i : stored_valid ? tmask_q[rd_q] : '0;
        out_pc_o    = byp ? in_pc_i    : stored_valid ? pc_q[rd_q]    : '0;
        out_instr_o = byp ? in_instr_i : stored_valid ? instr_q[rd_q] : '0;
        count_d     = count_q + CNT_BITS'(push_st) - CNT_BITS'(pop_st);
        rd_d        = rd_q + AW'(pop_st);
        wr_d        = wr_q + AW'(push_st);
    end

    assign count_o = count_q;
    assign busy_o  = (count_q != '0) || in_valid_i;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
        if (push_st) begin
            wid_q[wr_q]   <= in_wid_i;
            tmask_q[wr_q] <= in_tmask_i;
            pc_q[wr_q]    <= in_pc_i;
            instr_q[wr_q] <= in_instr_i;
        end
    end
endmodule

// File: tb/tb_vx_ifetch_buffer.sv
// tb_vx_ifetch_buffer: scoreboard bench; a queue models the buffer, checked every cycle at negedge.
module tb_vx_ifetch_buffer;
    localparam int D = 4;
    typedef logic [69:0] ent_t;

    logic        clk = 0, rst = 1, flush = 0, iv = 0, ordy = 0;
    logic [1:0]  wid = 0;
    logic [3:0]  tm = 0;
    logic [31:0] pc = 0, ins = 0;
    logic        in_ready, out_valid, busy;
    logic [1:0]  out_wid;
    logic [3:0]  out_tmask;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;
    ent_t        q[$];
    int          n_cmp = 0, n_err = 0;
    bit          chk_en = 0;

    always #5 clk = ~clk;

    vx_ifetch_buffer #(.NUM_WARPS(4), .NUM_THREADS(4), .DEPTH(D)) dut (
        .clk_i(clk), .reset_i(rst), .flush_i(flush),
        .in_valid_i(iv), .in_wid_i(wid), .in_tmask_i(tm), .in_pc_i(pc), .in_instr_i(ins),
        .in_ready_o(in_ready), .out_valid_o(out_valid),
        .out_wid_o(out_wid), .out_tmask_o(out_tmask), .out_pc_o(out_pc), .out_instr_o(out_instr),
        .out_ready_i(ordy), .count_o(count), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit   byp, ev, er;
            ent_t ein, eo;
            ein = {wid, tm, pc, ins};
            er  = !rst && !flush && (q.size() != D);
            byp = 0;
`ifdef VX_IFETCH_BUF_BYPASS_EN
            byp = (q.size() == 0) && iv && ordy && !flush && !rst;
`endif
            ev = byp || ((q.size() != 0) && !flush && !rst);
            eo = byp ? ein : ev ? q[0] : '0;
            check("in_ready", 70'(in_ready), 70'(er));
            check("out_valid", 70'(out_valid), 70'(ev));
            check("count", 70'(count), 70'(q.size()));
            check("busy", 70'(busy), 70'((q.size() != 0) || iv));
            check("out_data", {out_wid, out_tmask, out_pc, out_instr}, eo);
            if (rst || flush) q.delete();
            else if (!byp) begin
                if (ev && ordy) void'(q.pop_front());
                if (iv && er) q.push_back(ein);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] w, input logic [31:0] p,
                         input logic [31:0] i, input bit r);
        iv = v; wid = w; pc = p; ins = i; tm = 4'hF ^ {w, w}; ordy = r;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        drive(0, 0, 0, 0, 1);
        rst = 0;
        repeat (2) drive(0, 0, 0, 0, 1);
        drive(1, 1, 32'h8000_0000, 32'h0000_0013, 1);
        repeat (2) drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) drive(1, 2'(k), 32'(4 * k), 32'h100 + 32'(k), 0);
        repeat (2) drive(1, 3, 32'h10, 32'h104, 0);
        repeat (2) drive(1, 3, 32'h10, 32'h104, 1);
        repeat (5) drive(0, 0, 0, 0, 1);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) drive(1, 2'(k), 32'h20 + 32'(4 * k), 32'h200 + 32'(k), 0);
            if (pass == 0) flush = 1; else rst = 1;
            drive(1, 0, 32'h2C, 32'h203, 0);
            flush = 0; rst = 0;
            drive(1, 2, 32'h100, 32'h300, 0);
            repeat (3) drive(0, 0, 0, 0, 1);
        end
        for (int n = 0; n < 300; n++) begin
            flush = ($urandom_range(0, 30) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0);
            flush = 0;
        end
        repeat (6) drive(0, 0, 0, 0, 1);
        check("end_count", 70'(count), 70'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vx_ifetch_buffer.md
# vx_ifetch_buffer

Elastic instruction-response buffer between the fetch stage (warp scheduler plus icache stage) and decode. Accepts fetched instructions (warp id, thread mask, PC, instruction word) over a valid/ready handshake, holds up to DEPTH entries in arrival order, and presents them to decode. It decouples icache response timing from decode backpressure. It also exports occupancy and busy status so the scheduler can throttle issue and the core can detect idle.

## Interface
- NUM_WARPS, 4: warps per core; NW_BITS = max(1, clog2(NUM_WARPS)).
- NUM_THREADS, 4: threads per warp; width of tmask.
- DEPTH, 4: entry count; power of two, 2..16; CNT_BITS = clog2(DEPTH)+1.

- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous discard of all buffered entries (kill/redirect).
- in_valid  in  1  fetch response valid.
- in_wid  in  NW_BITS  warp id.
- in_tmask  in  NUM_THREADS  thread mask.
- in_PC  in  32  instruction PC.
- in_instr  in  32  instruction word.
- in_ready  out  1  buffer can accept this cycle.
- out_valid  out  1  head entry valid toward decode.
- out_wid, out_tmask, out_PC, out_instr  out  NW_BITS/NUM_THREADS/32/32  head entry fields.
- out_ready  in  1  decode accepts head.
- count  out  CNT_BITS  current entries held, 0..DEPTH.
- busy  out  1  count != 0 or in_valid.

## Operation
- Storage: DEPTH-entry circular array; rd_ptr, wr_ptr of clog2(DEPTH) bits, wrap modulo DEPTH; separate count register (no pointer-compare ambiguity).
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = !reset && !flush && (count != DEPTH). Full buffer never accepts, even with a same-cycle pop.
- out_valid = (count != 0) && !flush, except in bypass (see Configuration).
- Data outputs are forced to zero whenever out_valid = 0.
- count update: push&&!pop: +1; pop&&!push: -1; both or neither: unchanged. count never exceeds DEPTH or underflows; pop requires count != 0.
- Order strictly FIFO across all warps; no per-warp reordering.
- flush: next cycle count = 0 and rd_ptr = wr_ptr = 0. Same-cycle push is impossible (in_ready = 0). Same-cycle pop is impossible (out_valid = 0). Entries are discarded, not delivered.
- reset: same effect as flush. Dominates all inputs.
- Reset values: count 0, out_valid 0, out data 0, in_ready 0 while reset is high and 1 on the first cycle after, busy = in_valid.
- Mid-operation reset or flush with a partially full buffer: all entries are lost and no stale entry appears afterward.

## Timing
- Without bypass: a pushed entry is visible at out_valid on the next cycle (1-cycle latency), even when the buffer was empty.
- Throughput 1 entry/cycle sustained when 0 < count < DEPTH and out_ready = 1.
- in_ready, out_valid, and data outputs depend only on registered state plus flush/reset, except in bypass. No combinational in_valid-to-in_ready or out_ready-to-in_ready path.
- Array write occurs on the push edge; the head read is combinational from the array at rd_ptr.

## Configuration
- VX_IFETCH_BUF_BYPASS_EN defined: when count == 0 and in_valid && out_ready && !flush, the input passes combinationally to the output (out_valid = 1, data = in_*). The entry is consumed in the same cycle, with 0-cycle latency. No write occurs and count stays 0. If out_ready = 0, the entry is stored normally.
- Undefined: no bypass path; latency is always at least 1 cycle; outputs are fully registered-state driven.

## Test plan
- Reset, then idle: count = 0, out_valid = 0, out data 0, in_ready = 1 from the first post-reset cycle.
- Push wid = 1, PC = 0x8000_0000, instr = 0x0000_0013 with out_ready = 1, bypass off: out_valid rises the next cycle with identical fields; count goes 1 then 0.
- Hold out_ready = 0 and push 5 entries with DEPTH = 4: first 4 accepted, in_ready = 0 at count = 4, 5th held upstream. Release out_ready: entries drain in order PC 0x...00, 04, 08, 0C, then the 5th is accepted.
- Full buffer with simultaneous in_valid and out_ready: one pop, no push, count 4 goes to 3. Next cycle the push is accepted and count returns to 4.
- flush at count = 3: next cycle count = 0 and out_valid = 0. A subsequent push of PC 0x100 emerges first, with no stale entries. Repeat the sequence using reset instead of flush.
- Bypass on, empty buffer, in_valid = out_ready = 1: out_valid = 1 in the same cycle, out_PC = in_PC, count stays 0. With out_ready = 0, the entry is stored and count = 1.
